// File: rtl/turfio_pkg.sv
// Shared definitions for the TURFIO bank sequencer: the per-bank state encoding,
// the register map, and the field offsets used by both the bus decode and the FSMs.
package turfio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MMCM_RST  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_IDC_RST   = 3'd3,
        ST_WAIT_RDY  = 3'd4,
        ST_BANK_RST  = 3'd5,
        ST_DONE      = 3'd6
    } bank_state_t;

    // Word addresses, taken from wb_adr_i[13:2]
    localparam logic [11:0] ADDR_CONTROL = 12'd0;
    localparam logic [11:0] ADDR_STATUS  = 12'd1;

    localparam int CTRL_MMCM_LSB  = 0;
    localparam int CTRL_IDC_LSB   = 8;
    localparam int CTRL_BANK_LSB  = 16;
    localparam int CTRL_START_LSB = 24;

    localparam int STAT_LOCK_LSB  = 0;
    localparam int STAT_RDY_LSB   = 8;
    localparam int STAT_READY_LSB = 16;
    localparam int STAT_TMO_LSB   = 24;
    localparam int STAT_LOST_LSB  = 28;

    // One shared counter times both the reset pulses and the wait timeouts.
    function automatic int cnt_width(input int rst_cycles, input int timeout_cycles);
        int m;
        m = (rst_cycles > timeout_cycles) ? rst_cycles : timeout_cycles;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/turfio_bank_fsm.sv
// One bank's reset sequencer: MMCM reset, wait for lock, IDELAYCTRL reset, wait for
// ready, bank reset, then hold in DONE while lock and ready stay up.
module turfio_bank_fsm
    import turfio_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter     WBCLKTYPE      = "NONE"
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic locked_i,
    input  logic rdy_i,
    input  logic man_mmcm_rst_i,
    input  logic man_idc_rst_i,
    input  logic man_bank_rst_i,
    output logic mmcm_rst_o,
    output logic idc_rst_o,
    output logic bank_rst_o,
    output logic ready_o,
    output logic timeout_o,
    output logic lock_lost_o
);

    localparam int CNT_W = cnt_width(RST_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bank_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             lost_q, lost_d;
    logic             mmcm_rst_d, idc_rst_d, bank_rst_d, ready_d;

    (* CUSTOM_CC_SRC = WBCLKTYPE *) logic mmcm_rst_q;
    (* CUSTOM_CC_SRC = WBCLKTYPE *) logic idc_rst_q;
    (* CUSTOM_CC_SRC = WBCLKTYPE *) logic bank_rst_q;
    (* CUSTOM_CC_SRC = WBCLKTYPE *) logic ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        lost_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_MMCM_RST;
                    cnt_d   = '0;
                end
            end
            ST_MMCM_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_i) begin
                    state_d = ST_IDC_RST;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDC_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_RDY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_i) begin
                    state_d = ST_BANK_RST;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BANK_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Loss of lock/ready outranks a simultaneous restart request.
                if (!locked_i || !rdy_i) begin
                    state_d = ST_IDLE;
                    lost_d  = 1'b1;
                end else if (start_i) begin
                    state_d = ST_MMCM_RST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        mmcm_rst_d = man_mmcm_rst_i | (state_d == ST_MMCM_RST);
        idc_rst_d  = man_idc_rst_i  | (state_d == ST_IDC_RST);
        bank_rst_d = man_bank_rst_i | (state_d == ST_BANK_RST);
        ready_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            lost_q     <= 1'b0;
            mmcm_rst_q <= 1'b0;
            idc_rst_q  <= 1'b0;
            bank_rst_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            lost_q     <= lost_d;
            mmcm_rst_q <= mmcm_rst_d;
            idc_rst_q  <= idc_rst_d;
            bank_rst_q <= bank_rst_d;
            ready_q    <= ready_d;
        end
    end

    assign mmcm_rst_o  = mmcm_rst_q;
    assign idc_rst_o   = idc_rst_q;
    assign bank_rst_o  = bank_rst_q;
    assign ready_o     = ready_q;
    assign timeout_o   = timeout_q;
    assign lock_lost_o = lost_q;

endmodule

// File: rtl/turfio_bank_seq.sv
// WISHBONE-controlled power-up sequencer for NUM_BANKS I/O banks: synchronizes the
// MMCM/IDELAYCTRL status, exposes CONTROL/STATUS registers and runs one FSM per bank.
module turfio_bank_seq
    import turfio_pkg::*;
#(
    parameter int NUM_BANKS      = 2,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter     WBCLKTYPE      = "NONE"
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [14:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    input  logic [NUM_BANKS-1:0] mmcm_locked_i,
    input  logic [NUM_BANKS-1:0] idelayctrl_rdy_i,
    output logic [NUM_BANKS-1:0] mmcm_rst_o,
    output logic [NUM_BANKS-1:0] idelayctrl_rst_o,
    output logic [NUM_BANKS-1:0] bank_rst_o,
    output logic [NUM_BANKS-1:0] bank_ready_o
);

    (* ASYNC_REG = "TRUE" *) logic [NUM_BANKS-1:0] locked_meta_q;
    (* ASYNC_REG = "TRUE" *) logic [NUM_BANKS-1:0] locked_sync_q;
    (* ASYNC_REG = "TRUE" *) logic [NUM_BANKS-1:0] rdy_meta_q;
    (* ASYNC_REG = "TRUE" *) logic [NUM_BANKS-1:0] rdy_sync_q;

    logic [NUM_BANKS-1:0] man_mmcm_q, man_mmcm_d;
    logic [NUM_BANKS-1:0] man_idc_q,  man_idc_d;
    logic [NUM_BANKS-1:0] man_bank_q, man_bank_d;
    logic [NUM_BANKS-1:0] tmo_flag_q, tmo_flag_d;
    logic [NUM_BANKS-1:0] lost_flag_q, lost_flag_d;

    (* CUSTOM_CC_SRC = WBCLKTYPE *) logic        ack_q;
    (* CUSTOM_CC_SRC = WBCLKTYPE *) logic [31:0] dat_q;
    logic        ack_d;
    logic [31:0] dat_d;

    logic                 access, ctrl_wr, stat_wr;
    logic [11:0]          word;
    logic [31:0]          rdata;
    logic [NUM_BANKS-1:0] start, tmo_clr, lost_clr;
    logic [NUM_BANKS-1:0] fsm_timeout, fsm_lost;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

    always_comb begin
        // ack_q blocks a second access while the current one is being acknowledged.
        access  = wb_cyc_i & wb_stb_i & ~wb_adr_i[14] & ~ack_q;
        word    = wb_adr_i[13:2];
        ctrl_wr = access & wb_we_i & (word == ADDR_CONTROL);
        stat_wr = access & wb_we_i & (word == ADDR_STATUS);

        man_mmcm_d = man_mmcm_q;
        man_idc_d  = man_idc_q;
        man_bank_d = man_bank_q;
        start      = '0;
        tmo_clr    = '0;
        lost_clr   = '0;

        if (ctrl_wr && wb_sel_i[CTRL_MMCM_LSB/8])
            man_mmcm_d = wb_dat_i[CTRL_MMCM_LSB +: NUM_BANKS];
        if (ctrl_wr && wb_sel_i[CTRL_IDC_LSB/8])
            man_idc_d = wb_dat_i[CTRL_IDC_LSB +: NUM_BANKS];
        if (ctrl_wr && wb_sel_i[CTRL_BANK_LSB/8])
            man_bank_d = wb_dat_i[CTRL_BANK_LSB +: NUM_BANKS];
        if (ctrl_wr && wb_sel_i[CTRL_START_LSB/8])
            start = wb_dat_i[CTRL_START_LSB +: NUM_BANKS];
        if (stat_wr && wb_sel_i[STAT_TMO_LSB/8])
            tmo_clr = wb_dat_i[STAT_TMO_LSB +: NUM_BANKS];
        if (stat_wr && wb_sel_i[STAT_LOST_LSB/8])
            lost_clr = wb_dat_i[STAT_LOST_LSB +: NUM_BANKS];

        // A set pulse in the same cycle as a clear keeps the flag.
        tmo_flag_d  = (tmo_flag_q  & ~tmo_clr)  | fsm_timeout;
        lost_flag_d = (lost_flag_q & ~lost_clr) | fsm_lost;

        rdata = '0;
        if (word == ADDR_CONTROL) begin
            rdata[CTRL_MMCM_LSB +: NUM_BANKS] = man_mmcm_q;
            rdata[CTRL_IDC_LSB  +: NUM_BANKS] = man_idc_q;
            rdata[CTRL_BANK_LSB +: NUM_BANKS] = man_bank_q;
        end else if (word == ADDR_STATUS) begin
            rdata[STAT_LOCK_LSB  +: NUM_BANKS] = locked_sync_q;
            rdata[STAT_RDY_LSB   +: NUM_BANKS] = rdy_sync_q;
            rdata[STAT_READY_LSB +: NUM_BANKS] = bank_ready_o;
            rdata[STAT_TMO_LSB   +: NUM_BANKS] = tmo_flag_q;
            rdata[STAT_LOST_LSB  +: NUM_BANKS] = lost_flag_q;
        end

        ack_d = access;
        dat_d = (access && !wb_we_i) ? rdata : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_meta_q <= '0;
            locked_sync_q <= '0;
            rdy_meta_q    <= '0;
            rdy_sync_q    <= '0;
            man_mmcm_q    <= '0;
            man_idc_q     <= '0;
            man_bank_q    <= '0;
            tmo_flag_q    <= '0;
            lost_flag_q   <= '0;
            ack_q         <= 1'b0;
            dat_q         <= '0;
        end else begin
            locked_meta_q <= mmcm_locked_i;
            locked_sync_q <= locked_meta_q;
            rdy_meta_q    <= idelayctrl_rdy_i;
            rdy_sync_q    <= rdy_meta_q;
            man_mmcm_q    <= man_mmcm_d;
            man_idc_q     <= man_idc_d;
            man_bank_q    <= man_bank_d;
            tmo_flag_q    <= tmo_flag_d;
            lost_flag_q   <= lost_flag_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
        end
    end

    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_dat_o = dat_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        turfio_bank_fsm #(
            .RST_CYCLES     (RST_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .WBCLKTYPE      (WBCLKTYPE)
        ) u_fsm (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .start_i        (start[gi]),
            .locked_i       (locked_sync_q[gi]),
            .rdy_i          (rdy_sync_q[gi]),
            .man_mmcm_rst_i (man_mmcm_q[gi]),
            .man_idc_rst_i  (man_idc_q[gi]),
            .man_bank_rst_i (man_bank_q[gi]),
            .mmcm_rst_o     (mmcm_rst_o[gi]),
            .idc_rst_o      (idelayctrl_rst_o[gi]),
            .bank_rst_o     (bank_rst_o[gi]),
            .ready_o        (bank_ready_o[gi]),
            .timeout_o      (fsm_timeout[gi]),
            .lock_lost_o    (fsm_lost[gi])
        );
    end

endmodule

// File: tb/tb_turfio_bank_seq.sv
// Directed bench for turfio_bank_seq with two banks, 4-cycle reset pulses and a
// 64-cycle wait timeout; every expected value below is worked out by hand.
module tb_turfio_bank_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [14:0] wb_adr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [1:0]  mmcm_locked_i = '0;
    logic [1:0]  idelayctrl_rdy_i = '0;
    logic [1:0]  mmcm_rst_o, idelayctrl_rst_o, bank_rst_o, bank_ready_o;

    int vectors = 0;
    int miscompares = 0;

    turfio_bank_seq #(
        .NUM_BANKS      (2),
        .RST_CYCLES     (4),
        .TIMEOUT_CYCLES (64),
        .WBCLKTYPE      ("NONE")
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wb_cyc_i         (wb_cyc_i),
        .wb_stb_i         (wb_stb_i),
        .wb_we_i          (wb_we_i),
        .wb_adr_i         (wb_adr_i),
        .wb_sel_i         (wb_sel_i),
        .wb_dat_i         (wb_dat_i),
        .wb_dat_o         (wb_dat_o),
        .wb_ack_o         (wb_ack_o),
        .wb_err_o         (wb_err_o),
        .wb_rty_o         (wb_rty_o),
        .mmcm_locked_i    (mmcm_locked_i),
        .idelayctrl_rdy_i (idelayctrl_rdy_i),
        .mmcm_rst_o       (mmcm_rst_o),
        .idelayctrl_rst_o (idelayctrl_rst_o),
        .bank_rst_o       (bank_rst_o),
        .bank_ready_o     (bank_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("vector %0d %s observed=0x%08h expected=0x%08h", vectors, tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, mmcm_rst_o, idelayctrl_rst_o, bank_rst_o, bank_ready_o};
    endfunction

    // Drives one access starting on a falling edge; returns on the falling edge
    // where the acknowledge is expected, with the bus already released.
    task automatic wb_xfer(input string tag, input logic we, input logic [14:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output logic [31:0] rdat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        @(negedge clk_i);
        check({tag, "_ack"}, 32'(wb_ack_o), 32'd1);
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_dat_i = '0; wb_sel_i = '0;
    endtask

    task automatic wb_write(input string tag, input logic [14:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] unused_rd;
        wb_xfer(tag, 1'b1, adr, dat, sel, unused_rd);
    endtask

    task automatic wb_read_check(input string tag, input logic [14:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(tag, 1'b0, adr, 32'd0, 4'hF, rd);
        check(tag, rd, exp);
    endtask

    function automatic logic sig(input int s, input bit b);
        case (s)
            0:       return mmcm_rst_o[b];
            1:       return idelayctrl_rst_o[b];
            default: return bank_rst_o[b];
        endcase
    endfunction

    // Waits (bounded) for a reset output to rise, then counts its high cycles.
    task automatic pulse_width(input int s, input bit b, input string tag, input int expw);
        int n = 0;
        int guard = 0;
        while (!sig(s, b) && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        while (sig(s, b) && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        check(tag, 32'(n), 32'(expw));
    endtask

    localparam logic [14:0] A_CTRL  = 15'h0000;
    localparam logic [14:0] A_STAT  = 15'h0004;
    localparam logic [14:0] A_OTHER = 15'h0008;
    localparam logic [14:0] A_HIGH  = 15'h4000;

    initial begin
        int guard;
        logic ack_seen;

        // Reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_outputs", outs(), 32'h0);
        check("reset_wb_flags", {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'h0);
        wb_read_check("reset_control", A_CTRL, 32'h0);
        wb_read_check("reset_status", A_STAT, 32'h0);

        // Byte-lane masked CONTROL write
        wb_write("ctrl_sel0", A_CTRL, 32'h0001_0101, 4'b0001);
        wb_read_check("ctrl_readback", A_CTRL, 32'h0000_0001);
        check("manual_mmcm_only", outs(), 32'b1000000);

        // Accesses with adr[14]=1 and to unmapped words
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = A_HIGH; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            ack_seen = ack_seen | wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("high_adr_no_ack", 32'(ack_seen), 32'd0);
        wb_read_check("high_adr_ctrl_kept", A_CTRL, 32'h0000_0001);
        wb_write("other_write", A_OTHER, 32'hFFFF_FFFF, 4'hF);
        wb_read_check("other_read", A_OTHER, 32'h0);
        wb_read_check("other_ctrl_kept", A_CTRL, 32'h0000_0001);
        wb_write("ctrl_clear", A_CTRL, 32'h0, 4'hF);
        @(negedge clk_i);
        check("manual_cleared", outs(), 32'h0);

        // Bank 0 lock timeout, then write-1-to-clear honouring sel
        wb_write("start0_tmo", A_CTRL, 32'h0100_0000, 4'b1000);
        pulse_width(0, 1'b0, "tmo_mmcm_width", 4);
        repeat (50) @(negedge clk_i);
        wb_read_check("tmo_not_yet", A_STAT, 32'h0);
        repeat (20) @(negedge clk_i);
        wb_read_check("tmo_flag_set", A_STAT, 32'h0100_0000);
        check("tmo_back_idle", outs(), 32'h0);
        wb_write("tmo_clr_wrong_lane", A_STAT, 32'h0100_0000, 4'b0111);
        wb_read_check("tmo_flag_kept", A_STAT, 32'h0100_0000);
        wb_write("tmo_clr", A_STAT, 32'h0100_0000, 4'b1000);
        wb_read_check("tmo_flag_cleared", A_STAT, 32'h0);

        // Full sequence on bank 0
        wb_write("start0", A_CTRL, 32'h0100_0000, 4'b1000);
        pulse_width(0, 1'b0, "seq_mmcm_width", 4);
        wb_write("start0_busy", A_CTRL, 32'h0100_0000, 4'b1000);
        check("start_ignored_busy", 32'(mmcm_rst_o[0]), 32'd0);
        repeat (4) @(negedge clk_i);
        mmcm_locked_i[0] = 1'b1;
        pulse_width(1, 1'b0, "seq_idc_width", 4);
        repeat (5) @(negedge clk_i);
        idelayctrl_rdy_i[0] = 1'b1;
        pulse_width(2, 1'b0, "seq_bank_width", 4);
        check("seq_done_outputs", outs(), 32'b00000001);
        wb_read_check("seq_status", A_STAT, 32'h0001_0101);

        // Bank 1 up, then lock loss on bank 1 only
        mmcm_locked_i[1] = 1'b1;
        idelayctrl_rdy_i[1] = 1'b1;
        wb_write("start1", A_CTRL, 32'h0200_0000, 4'b1000);
        guard = 0;
        while (!bank_ready_o[1] && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        check("both_ready", 32'(bank_ready_o), 32'h3);
        mmcm_locked_i[1] = 1'b0;
        repeat (3) @(negedge clk_i);
        check("lost1_ready", 32'(bank_ready_o), 32'h1);
        wb_read_check("lost1_status", A_STAT, 32'h2001_0301);

        // Reset during IDELAYCTRL reset, then a fresh full sequence
        wb_write("restart0", A_CTRL, 32'h0100_0000, 4'b1000);
        guard = 0;
        while (!idelayctrl_rst_o[0] && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        check("in_idc_rst", outs(), 32'b00010000);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midseq_reset_outputs", outs(), 32'h0);
        check("midseq_reset_ack", 32'(wb_ack_o), 32'd0);
        rst_i = 1'b0;
        wb_read_check("post_reset_ctrl", A_CTRL, 32'h0);
        wb_read_check("post_reset_status", A_STAT, 32'h0000_0301);
        wb_write("start0_again", A_CTRL, 32'h0100_0000, 4'b1000);
        pulse_width(0, 1'b0, "again_mmcm_width", 4);
        pulse_width(1, 1'b0, "again_idc_width", 4);
        pulse_width(2, 1'b0, "again_bank_width", 4);
        check("again_done_outputs", outs(), 32'b00000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
